bram_mat_seq: RTL and testbench
===============================

Name: bram_mat_seq

Overview:
- Sequencer and port arbiter for one single-port matrix BRAM of ROWS*COLS words, one-cycle read latency.
- Shares the single port between host writes (matrix load or repair) and a streaming read that feeds one systolic-array edge buffer.
- Streams in row-major order, or column-major when transposed, with a ready/valid output and full backpressure.

Parameters:
- ROWS, 4, matrix rows.
- COLS, 4, matrix columns.
- WORD_SIZE, 16, data width.
- ADDR_WIDTH, $clog2(ROWS*COLS), BRAM address width (derived, not overridden).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a stream pass when IDLE.
- transpose  in  1  sampled with start; 1 = column-major order.
- abort  in  1  terminates stream; returns to IDLE.
- wr_valid  in  1  host write request.
- wr_ready  out  1  host write accepted this cycle.
- wr_addr  in  ADDR_WIDTH  host write address.
- wr_data  in  WORD_SIZE  host write data.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_di  out  WORD_SIZE  BRAM write data.
- bram_dout  in  WORD_SIZE  BRAM read data, valid one cycle after its address.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer ready.
- out_data  out  WORD_SIZE  stream word.
- out_row  out  $clog2(ROWS) (min 1)  row index of out_data.
- out_col  out  $clog2(COLS) (min 1)  column index of out_data.
- out_last  out  1  marks final word of the pass.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after last word accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters, skid buffer and in-flight flag cleared.
- States:
  - IDLE: wr_ready = wr_valid. An accepted write drives bram_we=1, bram_addr=wr_addr, bram_di=wr_data combinationally in the same cycle. If start and wr_valid coincide, the write is accepted and start is ignored.
  - start in IDLE (without wr_valid): latch transpose, clear indices, go STREAM.
  - STREAM: wr_ready=0; bram_we=0.
    - Read issue: issue address (r*COLS+c) when issued count < ROWS*COLS and (skid occupancy + in-flight) < 2.
    - Next-index order: row-major advances c first, wrapping c at COLS-1 then incrementing r; column-major advances r first, wrapping r at ROWS-1 then incrementing c.
    - Read return: the word returned one cycle later enters a 2-entry FIFO with its r/c tags; the FIFO head drives out_*.
    - Transfer: occurs when out_valid & out_ready.
    - out_last=1 only on the word tagged with the ROWS*COLS-th issue.
    - When that last word transfers, go DONE.
  - DONE: done=1 for one cycle, busy=1 in that cycle; next state IDLE.
  - start in STREAM or DONE: ignored.
- abort in STREAM: next cycle is IDLE, FIFO flushed, in-flight read discarded, no done pulse, out_valid=0. abort takes priority over a simultaneous final transfer.
- out_data, out_row and out_col are stable while out_valid=1 and out_ready=0.
- Throughput: 1 word/cycle with out_ready held high. First out_valid is 2 cycles after the start cycle (cycle 1 issues addr 0, cycle 2 presents data).
- Pass latency with out_ready=1: done asserts ROWS*COLS+2 cycles after start.
- Reset mid-stream: immediate return to the reset state; BRAM contents are untouched.
- Row and column indices wrap with no overflow; the total issue counter is ADDR_WIDTH+1 bits wide.

Test Plan:
- Load then stream: write addr k = k+1 for k=0..15 (each wr_ready=1 same cycle), then start, transpose=0, out_ready=1 -> out_data 1..16 on consecutive cycles, (row,col) (0,0)..(3,3), out_last on 16, done 18 cycles after start.
- Transpose: same data, transpose=1 -> sequence 1,5,9,13,2,6,...,16; out_last on 16.
- Backpressure: out_ready toggled 1,0,0,1 repeating -> no word lost or duplicated, out_data held stable during stalls, never more than 2 reads outstanding or buffered.
- Arbitration: wr_valid held during STREAM -> wr_ready=0 and bram_we=0 throughout; the write is accepted in the first IDLE cycle after done. start with wr_valid in IDLE -> write accepted, busy stays 0.
- Abort: abort after the 5th transfer -> IDLE next cycle, out_valid=0, done never pulses; a following start streams the full 16 words again.
- Reset mid-stream: assert rst asynchronously between clock edges -> all outputs 0 immediately; after release, a start produces a correct full pass.

Source files
------------

// File: rtl/bram_mat_seq.sv
// Port arbiter and stream sequencer for a single-port matrix BRAM: host writes in IDLE,
// row- or column-major read stream with a 2-entry skid FIFO and full backpressure.
module bram_mat_seq #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned WORD_SIZE = 16,
    localparam int unsigned ADDR_WIDTH = $clog2(ROWS * COLS),
    localparam int unsigned ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  transpose,
    input  logic                  abort,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]  wr_data,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [WORD_SIZE-1:0]  bram_di,
    input  logic [WORD_SIZE-1:0]  bram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  out_data,
    output logic [ROW_W-1:0]      out_row,
    output logic [COL_W-1:0]      out_col,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NUM_WORDS = ROWS * COLS;
    localparam int unsigned CNT_W     = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_transpose;
    logic [ROW_W-1:0]       r_row;
    logic [COL_W-1:0]       r_col;
    logic [CNT_W-1:0]       r_issued;

    // Read in flight: its data appears on bram_dout this cycle.
    logic                   r_inflight;
    logic [ROW_W-1:0]       r_inf_row;
    logic [COL_W-1:0]       r_inf_col;
    logic                   r_inf_last;

    logic [WORD_SIZE-1:0]   r_fifo_data [2];
    logic [ROW_W-1:0]       r_fifo_row  [2];
    logic [COL_W-1:0]       r_fifo_col  [2];
    logic                   r_fifo_last [2];
    logic                   r_wptr;
    logic                   r_rptr;
    logic [1:0]             r_count;

    logic                   w_stream;
    logic                   w_start_acc;
    logic                   w_empty;
    logic                   w_issue;
    logic                   w_xfer;
    logic                   w_push;
    logic                   w_pop;
    logic [1:0]             w_count_nxt;
    logic [ROW_W-1:0]       w_row_nxt;
    logic [COL_W-1:0]       w_col_nxt;
    logic [ADDR_WIDTH-1:0]  w_issue_addr;
    logic [WORD_SIZE-1:0]   w_head_data;
    logic [ROW_W-1:0]       w_head_row;
    logic [COL_W-1:0]       w_head_col;
    logic                   w_head_last;
    logic                   w_out_valid;

    assign w_stream    = (r_state == StStream);
    assign w_start_acc = (r_state == StIdle) && start && !wr_valid;
    assign w_empty     = (r_count == 2'd0);

    // Skid occupancy plus in-flight read never exceeds two.
    assign w_issue = w_stream && !abort && (r_issued < CNT_W'(NUM_WORDS)) &&
                     ((3'(r_count) + 3'(r_inflight)) < 3'd2);

    assign w_issue_addr = ADDR_WIDTH'(r_row) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(r_col);

    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (r_transpose) begin
            if (r_row == ROW_W'(ROWS - 1)) begin
                w_row_nxt = '0;
                w_col_nxt = (r_col == COL_W'(COLS - 1)) ? '0 : r_col + 1'b1;
            end else begin
                w_row_nxt = r_row + 1'b1;
            end
        end else begin
            if (r_col == COL_W'(COLS - 1)) begin
                w_col_nxt = '0;
                w_row_nxt = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;
            end else begin
                w_col_nxt = r_col + 1'b1;
            end
        end
    end

    // An empty FIFO is bypassed so returning data is presented in its arrival cycle.
    always_comb begin
        if (w_empty) begin
            w_head_data = bram_dout;
            w_head_row  = r_inf_row;
            w_head_col  = r_inf_col;
            w_head_last = r_inf_last;
        end else begin
            w_head_data = r_fifo_data[r_rptr];
            w_head_row  = r_fifo_row[r_rptr];
            w_head_col  = r_fifo_col[r_rptr];
            w_head_last = r_fifo_last[r_rptr];
        end
    end

    assign w_out_valid = w_stream && !abort && (!w_empty || r_inflight);
    assign w_xfer      = w_out_valid && out_ready;
    assign w_push      = w_stream && r_inflight && !(w_empty && w_xfer);
    assign w_pop       = !w_empty && w_xfer;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:   if (w_start_acc) w_state_nxt = StStream;
            StStream: begin
                if (abort) begin
                    w_state_nxt = StIdle;
                end else if (w_xfer && w_head_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone:   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        wr_ready  = (r_state == StIdle) && wr_valid;
        bram_we   = wr_ready;
        bram_di   = wr_ready ? wr_data : '0;
        bram_addr = '0;
        if (wr_ready) begin
            bram_addr = wr_addr;
        end else if (w_issue) begin
            bram_addr = w_issue_addr;
        end
        out_valid = w_out_valid;
        out_data  = w_out_valid ? w_head_data : '0;
        out_row   = w_out_valid ? w_head_row : '0;
        out_col   = w_out_valid ? w_head_col : '0;
        out_last  = w_out_valid && w_head_last;
        busy      = (r_state != StIdle);
        done      = (r_state == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_transpose <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_issued    <= '0;
            r_inflight  <= 1'b0;
            r_inf_row   <= '0;
            r_inf_col   <= '0;
            r_inf_last  <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_row[i]  <= '0;
                r_fifo_col[i]  <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else if (w_start_acc) begin
            r_transpose <= transpose;
            r_row       <= '0;
            r_col       <= '0;
            r_issued    <= '0;
            r_inflight  <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
        end else if (w_stream && abort) begin
            r_inflight <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
        end else if (w_stream) begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_row  <= r_row;
                r_inf_col  <= r_col;
                r_inf_last <= (r_issued == CNT_W'(NUM_WORDS - 1));
                r_row      <= w_row_nxt;
                r_col      <= w_col_nxt;
                r_issued   <= r_issued + 1'b1;
            end
            if (w_push) begin
                r_fifo_data[r_wptr] <= bram_dout;
                r_fifo_row[r_wptr]  <= r_inf_row;
                r_fifo_col[r_wptr]  <= r_inf_col;
                r_fifo_last[r_wptr] <= r_inf_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_bram_mat_seq.sv
// Directed bench for bram_mat_seq: behavioural BRAM, scoreboard queue of expected stream words.
module tb_bram_mat_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        transpose;
    logic        abort;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        bram_we;
    logic [3:0]  bram_addr;
    logic [15:0] bram_di;
    logic [15:0] bram_dout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        l;
    } exp_t;

    exp_t        q[$];
    int          n_assert;
    int          n_fail;
    logic [15:0] mem [16];

    bram_mat_seq #(
        .ROWS      (4),
        .COLS      (4),
        .WORD_SIZE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .transpose (transpose),
        .abort     (abort),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_di   (bram_di),
        .bram_dout (bram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        bram_dout = 16'h0;
    end

    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_di;
        bram_dout <= mem[bram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presented word must match the scoreboard head, stalled or not.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("scoreboard_nonempty", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                chk("out_data", out_data, q[0].d);
                chk("out_row", out_row, q[0].r);
                chk("out_col", out_col, q[0].c);
                chk("out_last", out_last, q[0].l);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic push_expected(input logic tr);
        exp_t e;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                e.r = tr ? 2'(b) : 2'(a);
                e.c = tr ? 2'(a) : 2'(b);
                e.d = 16'(e.r * 4 + e.c + 1);
                e.l = (a == 3) && (b == 3);
                q.push_back(e);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_bram_we"}, bram_we, 0);
        chk({tag, "_bram_addr"}, bram_addr, 0);
        chk({tag, "_bram_di"}, bram_di, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_rowcol"}, {out_row, out_col, out_last}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Called at posedge+1 in IDLE; mode 0 = out_ready high, 1 = ready pattern 1,0,0,1.
    task automatic run_pass(input logic tr, input int mode, input logic hold_wr,
                            output int cyc_done);
        int first_v;
        first_v  = -1;
        cyc_done = -1;
        push_expected(tr);
        start     = 1'b1;
        transpose = tr;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (hold_wr) begin
                wr_valid = 1'b1;
                wr_addr  = 4'd5;
                wr_data  = 16'd6;
            end
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            @(negedge clk);
            if (first_v < 0 && out_valid) first_v = cyc;
            if (hold_wr) begin
                chk("wr_ready_in_stream", wr_ready, 0);
                chk("bram_we_in_stream", bram_we, 0);
            end
            if (done) begin
                cyc_done = cyc;
                break;
            end
        end
        if (mode == 0) chk("first_valid_cycle", first_v, 2);
        chk("scoreboard_drained", q.size(), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        if (hold_wr) begin
            @(negedge clk);
            chk("wr_ready_after_done", wr_ready, 1);
            chk("bram_we_after_done", bram_we, 1);
            chk("bram_addr_after_done", bram_addr, 5);
            @(posedge clk); #1;
            wr_valid = 1'b0;
        end
    endtask

    initial begin
        int cd;
        int xf;
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        transpose = 1'b0;
        abort     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 16'd0;
        out_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Load matrix: addr k <= k+1.
        for (int k = 0; k < 16; k++) begin
            wr_valid = 1'b1;
            wr_addr  = 4'(k);
            wr_data  = 16'(k + 1);
            @(negedge clk);
            chk("load_wr_ready", wr_ready, 1);
            chk("load_bram_we", bram_we, 1);
            chk("load_bram_addr", bram_addr, k);
            chk("load_bram_di", bram_di, k + 1);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;

        run_pass(1'b0, 0, 1'b0, cd);
        chk("rowmajor_done_latency", cd, 18);
        run_pass(1'b1, 0, 1'b0, cd);
        chk("transpose_done_latency", cd, 18);
        run_pass(1'b0, 1, 1'b0, cd);
        chk("backpressure_done_seen", 32'(cd > 18), 1);
        run_pass(1'b1, 1, 1'b0, cd);
        chk("backpressure_tr_done_seen", 32'(cd > 18), 1);
        run_pass(1'b0, 0, 1'b1, cd);
        chk("arbitration_done_latency", cd, 18);

        // start coinciding with a write in IDLE: write wins.
        wr_valid = 1'b1;
        wr_addr  = 4'd0;
        wr_data  = 16'd1;
        start    = 1'b1;
        @(negedge clk);
        chk("start_wr_wr_ready", wr_ready, 1);
        chk("start_wr_bram_we", bram_we, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        chk("start_wr_busy", busy, 0);
        @(posedge clk); #1;

        // Abort after the 5th transfer.
        push_expected(1'b0);
        start     = 1'b1;
        transpose = 1'b0;
        out_ready = 1'b1;
        xf = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (out_valid && out_ready) xf++;
            if (xf == 5) break;
        end
        chk("abort_transfers", xf, 5);
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_cycle_out_valid", out_valid, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        q.delete();
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", done, 0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        run_pass(1'b0, 0, 1'b0, cd);
        chk("post_abort_done_latency", cd, 18);

        // Asynchronous reset mid-stream.
        push_expected(1'b0);
        start = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        q.delete();
        @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        run_pass(1'b1, 0, 1'b0, cd);
        chk("post_reset_done_latency", cd, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
